// File: rtl/data_mem_ctrl.sv
// Word-organised data memory with a req/valid handshake, configurable wait states
// and byte-lane merging for sub-word stores. Loads return the word shifted by the byte offset.
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        valid,
    output logic        err,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic m;
        case (sz)
            2'd0:    m = 1'b0;
            2'd1:    m = off[0];
            2'd2:    m = |off;
            default: m = 1'b1;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << {off[1], 1'b0};
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        end
        return res;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic [CW-1:0]  cnt_r;
    logic           we_r;
    logic [1:0]     size_r;
    logic [AW+1:0]  addr_r;
    logic [31:0]    wdata_r;
    logic           busy_r;
    logic           valid_r;
    logic           err_r;
    logic [31:0]    rdata_r;

    logic           accept_s;
    logic           misalign_s;
    logic           access_s;
    logic [AW-1:0]  idx_s;
    logic [31:0]    rd_word_s;
    logic [31:0]    load_data_s;
    logic [31:0]    store_data_s;
    logic [3:0]     store_be_s;
    logic           unused_bits_s;

    logic [31:0]    mem [DEPTH];

    // size[2] is the sign/zero choice handled downstream; high address bits wrap away
    assign unused_bits_s = ^{size[2], addr[31:AW+2]};

    assign idx_s        = addr_r[AW+1:2];
    assign rd_word_s    = mem[idx_s];
    assign load_data_s  = rd_word_s >> {addr_r[1:0], 3'b000};
    assign store_data_s = wdata_r << {addr_r[1:0], 3'b000};
    assign store_be_s   = lane_enable(size_r, addr_r[1:0]);

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        misalign_s   = is_misaligned(size[1:0], addr[1:0]);
        case (state_r)
            IDLE: begin
                if (req) begin
                    accept_s     = 1'b1;
                    state_next_s = misalign_s ? DONE : BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == {CW{1'b0}}) begin
                    access_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latch, wait counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            we_r    <= 1'b0;
            size_r  <= 2'd0;
            addr_r  <= {(AW+2){1'b0}};
            wdata_r <= 32'd0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            busy_r  <= (state_next_s != IDLE);
            valid_r <= (state_next_s == DONE);
            if (accept_s) begin
                we_r    <= we;
                size_r  <= size[1:0];
                addr_r  <= addr[AW+1:0];
                wdata_r <= wdata;
                cnt_r   <= CW'(WAIT_CYCLES);
                if (misalign_s) begin
                    err_r   <= 1'b1;
                    rdata_r <= 32'd0;
                end
            end else if (access_s) begin
                err_r   <= 1'b0;
                rdata_r <= we_r ? 32'd0 : load_data_s;
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (access_s && we_r) begin
            mem[idx_s] <= merge_lanes(rd_word_s, store_data_s, store_be_s);
        end
    end

    assign busy  = busy_r;
    assign valid = valid_r;
    assign err   = err_r;
    assign rdata = rdata_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: vector table plus scoreboard of expected
// completions, with hand-written sequences for held requests and mid-access reset.
module tb_data_mem_ctrl;

    localparam int WAIT = 2;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        valid;
    logic        err;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    data_mem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .valid (valid),
        .err   (err),
        .rdata (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_valid: got valid with empty scoreboard");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_err", {31'd0, err}, {31'd0, e.err});
                check("sb_rdata", rdata, e.rdata);
            end
        end
    end

    task automatic run_access(input vec_t v);
        int   k;
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = v.we;
        size  = v.size;
        addr  = v.addr;
        wdata = v.wdata;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            req = 1'b0;
            k++;
        end while (!valid && k < 20);
        if (!valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no valid for addr 0x%08h", v.addr);
            sb.delete();
        end else begin
            check("latency", 32'(k), v.exp_err ? 32'd1 : 32'(WAIT + 2));
        end
        @(negedge clk);
        check("valid_pulse", {31'd0, valid}, 32'd0);
        check("rdata_hold", rdata, v.exp_rdata);
        check("err_hold", {31'd0, err}, {31'd0, v.exp_err});
    endtask

    initial begin
        int n0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        size  = 3'd0;
        addr  = 32'd0;
        wdata = 32'd0;

        //         we    size  addr        wdata         err   rdata
        vecs.push_back('{1'b1, 3'd2, 32'h10,   32'h12345678, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h12345678});
        vecs.push_back('{1'b1, 3'd0, 32'h11,   32'hFFFFFFAB, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h1234AB78});
        vecs.push_back('{1'b0, 3'd0, 32'h13,   32'h0,        1'b0, 32'h00000012});
        vecs.push_back('{1'b1, 3'd2, 32'h20,   32'h11223344, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 3'd1, 32'h22,   32'h5555BEEF, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'd1, 32'h22,   32'h0,        1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b0, 3'd2, 32'h20,   32'h0,        1'b0, 32'hBEEF3344});
        vecs.push_back('{1'b0, 3'd5, 32'h22,   32'h0,        1'b0, 32'h0000BEEF});
        vecs.push_back('{1'b0, 3'd4, 32'h21,   32'h0,        1'b0, 32'h00BEEF33});
        vecs.push_back('{1'b1, 3'd2, 32'h12,   32'hDEADDEAD, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h1234AB78});
        vecs.push_back('{1'b0, 3'd1, 32'h13,   32'h0,        1'b1, 32'h0});
        vecs.push_back('{1'b1, 3'd3, 32'h10,   32'hFFFFFFFF, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h10,   32'h0,        1'b0, 32'h1234AB78});
        vecs.push_back('{1'b1, 3'd2, 32'h1000, 32'hCAFEF00D, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 3'd2, 32'h0,    32'h0,        1'b0, 32'hCAFEF00D});

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_access(vecs[i]);

        // req held high across two full access periods: exactly two completions
        @(negedge clk);
        n0 = n_valid;
        req = 1'b1; we = 1'b0; size = 3'd2; addr = 32'h0;
        sb.push_back('{1'b0, 32'hCAFEF00D});
        sb.push_back('{1'b0, 32'hCAFEF00D});
        repeat (10) @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (12) @(negedge clk);
        check("held_req_count", 32'(n_valid - n0), 32'd2);
        check("held_req_sb_empty", 32'(sb.size()), 32'd0);

        run_access('{1'b1, 3'd2, 32'h30, 32'h0BADBEEF, 1'b0, 32'h0});
        run_access('{1'b0, 3'd2, 32'h30, 32'h0,        1'b0, 32'h0BADBEEF});

        // Async reset during the wait states of a store: no commit, outputs cleared at once
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 3'd2; addr = 32'h30; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_busy", {31'd0, busy}, 32'd0);
        check("areset_valid", {31'd0, valid}, 32'd0);
        check("areset_err", {31'd0, err}, 32'd0);
        check("areset_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", {31'd0, busy}, 32'd0);
        run_access('{1'b0, 3'd2, 32'h30, 32'h0, 1'b0, 32'h0BADBEEF});

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
